// File: rtl/alu_exec_pipe_pkg.sv
// -----------------------------------------------------------------------------
// alu_defs
//   Shared ALU control code definitions. The ALU control decoder produces these
//   codes and the execute pipe consumes them, so both sides import this package.
//
//   Contents:
//     ALU_CTRL_W   width of the ALU control code
//     alu_ctrl_t   control code type
//     ALU_*        the five defined operation codes
//     alu_is_legal helper: 1 when a code is one of the defined operations
// -----------------------------------------------------------------------------
package alu_defs;

   localparam int ALU_CTRL_W = 4;

   typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

   localparam alu_ctrl_t ALU_AND   = 4'b0000;
   localparam alu_ctrl_t ALU_OR    = 4'b0001;
   localparam alu_ctrl_t ALU_ADD   = 4'b0010;
   localparam alu_ctrl_t ALU_SUB   = 4'b0110;
   localparam alu_ctrl_t ALU_PASSB = 4'b0111;

   function automatic logic alu_is_legal(input alu_ctrl_t ctrl);
      return (ctrl == ALU_AND) || (ctrl == ALU_OR) || (ctrl == ALU_ADD) ||
             (ctrl == ALU_SUB) || (ctrl == ALU_PASSB);
   endfunction

endpackage

// File: rtl/alu_comb_core.sv
// -----------------------------------------------------------------------------
// alu_comb_core
//   Purely combinational ALU datapath: control code plus two operands in,
//   result plus LEGv8 NZVC flags and an illegal-code flag out.
//
//   Ports:
//     ctrl_i     ALU control code
//     a_i, b_i   operands
//     result_o   result (0 for undefined codes)
//     n_o, z_o   negative / zero, derived from the result for every code
//     v_o, c_o   overflow / carry, only nonzero for ADD and SUB
//     illegal_o  ctrl_i is not one of the defined codes
// -----------------------------------------------------------------------------
module alu_comb_core
   import alu_defs::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [ALU_CTRL_W-1:0] ctrl_i,
   input  logic [WIDTH-1:0]      a_i,
   input  logic [WIDTH-1:0]      b_i,
   output logic [WIDTH-1:0]      result_o,
   output logic                  n_o,
   output logic                  z_o,
   output logic                  v_o,
   output logic                  c_o,
   output logic                  illegal_o
);

   localparam int MSB = WIDTH - 1;

   // One extra bit on the adder captures the carry out.
   logic [WIDTH:0] sum_ext;

   always_comb begin
      sum_ext   = '0;
      result_o  = '0;
      v_o       = 1'b0;
      c_o       = 1'b0;
      illegal_o = !alu_is_legal(ctrl_i);

      case (ctrl_i)
         ALU_AND:   result_o = a_i & b_i;
         ALU_OR:    result_o = a_i | b_i;
         ALU_ADD: begin
            sum_ext  = {1'b0, a_i} + {1'b0, b_i};
            result_o = sum_ext[MSB:0];
            c_o      = sum_ext[WIDTH];
            v_o      = (a_i[MSB] == b_i[MSB]) && (sum_ext[MSB] != a_i[MSB]);
         end
         ALU_SUB: begin
            // Two's-complement subtract: carry out of 1 means no borrow.
            sum_ext  = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
            result_o = sum_ext[MSB:0];
            c_o      = sum_ext[WIDTH];
            v_o      = (a_i[MSB] != b_i[MSB]) && (sum_ext[MSB] != a_i[MSB]);
         end
         ALU_PASSB: result_o = b_i;
         default:   result_o = '0;
      endcase

      n_o = result_o[MSB];
      z_o = (result_o == '0);
   end

endmodule

// File: rtl/alu_exec_pipe.sv
// -----------------------------------------------------------------------------
// alu_exec_pipe
//   Execute-stage ALU wrapped in a 2-stage valid/ready pipeline. S1 registers
//   the operation (ctrl/a/b/tag); alu_comb_core computes between S1 and S2; S2
//   registers the result and flags, which drive the outputs directly.
//
//   Ports:
//     CLK, Reset               clock; synchronous active-high reset
//     in_valid / in_ready      upstream handshake
//     in_ctrl, in_a, in_b      ALU control code and operands
//     in_tag                   destination tag, carried through unchanged
//     out_valid / out_ready    downstream handshake
//     out_result, out_tag      result and its tag
//     out_n/z/v/c              NZVC flags
//     out_illegal              in_ctrl was not a defined code
//
//   Handshake: a transfer happens on a rising edge where valid & ready are both
//   high. While out_valid & !out_ready every out_* holds stable. in_valid may
//   drop without a transfer. in_ready is the only combinational path from an
//   input (out_ready) to an output.
// -----------------------------------------------------------------------------
module alu_exec_pipe
   import alu_defs::*;
#(
   parameter int WIDTH = 64,
   parameter int TAG_W = 5
) (
   input  logic                  CLK,
   input  logic                  Reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [ALU_CTRL_W-1:0] in_ctrl,
   input  logic [WIDTH-1:0]      in_a,
   input  logic [WIDTH-1:0]      in_b,
   input  logic [TAG_W-1:0]      in_tag,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [WIDTH-1:0]      out_result,
   output logic [TAG_W-1:0]      out_tag,
   output logic                  out_n,
   output logic                  out_z,
   output logic                  out_v,
   output logic                  out_c,
   output logic                  out_illegal
);

   // S1: operation registers
   logic                  s1_valid_q, s1_valid_d;
   logic [ALU_CTRL_W-1:0] s1_ctrl_q;
   logic [WIDTH-1:0]      s1_a_q, s1_b_q;
   logic [TAG_W-1:0]      s1_tag_q;

   // S2: result registers
   logic                  s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0]      s2_result_q;
   logic [TAG_W-1:0]      s2_tag_q;
   logic                  s2_n_q, s2_z_q, s2_v_q, s2_c_q, s2_illegal_q;

   // Combinational core outputs
   logic [WIDTH-1:0]      core_result;
   logic                  core_n, core_z, core_v, core_c, core_illegal;

   logic                  s2_adv, s1_adv, s1_load, s2_load;

   alu_comb_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .ctrl_i    (s1_ctrl_q),
      .a_i       (s1_a_q),
      .b_i       (s1_b_q),
      .result_o  (core_result),
      .n_o       (core_n),
      .z_o       (core_z),
      .v_o       (core_v),
      .c_o       (core_c),
      .illegal_o (core_illegal)
   );

   // A stage may advance when it is empty or the stage after it is advancing.
   // S1 advancing into a draining S2 on the same edge gives full throughput.
   always_comb begin
      s2_adv     = !s2_valid_q || out_ready;
      s1_adv     = !s1_valid_q || s2_adv;
      s1_load    = in_valid && s1_adv;
      s2_load    = s1_valid_q && s2_adv;
      s1_valid_d = s1_adv ? in_valid   : s1_valid_q;
      s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
   end

   assign in_ready = s1_adv;

   // Valid bits and the output-facing S2 registers reset; a same-cycle
   // in_valid is ignored because the valid bits are cleared.
   always_ff @(posedge CLK) begin
      if (Reset) begin
         s1_valid_q   <= 1'b0;
         s2_valid_q   <= 1'b0;
         s2_result_q  <= '0;
         s2_tag_q     <= '0;
         s2_n_q       <= 1'b0;
         s2_z_q       <= 1'b0;
         s2_v_q       <= 1'b0;
         s2_c_q       <= 1'b0;
         s2_illegal_q <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         if (s2_load) begin
            s2_result_q  <= core_result;
            s2_tag_q     <= s1_tag_q;
            s2_n_q       <= core_n;
            s2_z_q       <= core_z;
            s2_v_q       <= core_v;
            s2_c_q       <= core_c;
            s2_illegal_q <= core_illegal;
         end
      end
   end

   // S1 data is only meaningful behind s1_valid_q, so it needs no reset.
   always_ff @(posedge CLK) begin
      if (s1_load) begin
         s1_ctrl_q <= in_ctrl;
         s1_a_q    <= in_a;
         s1_b_q    <= in_b;
         s1_tag_q  <= in_tag;
      end
   end

   assign out_valid   = s2_valid_q;
   assign out_result  = s2_result_q;
   assign out_tag     = s2_tag_q;
   assign out_n       = s2_n_q;
   assign out_z       = s2_z_q;
   assign out_v       = s2_v_q;
   assign out_c       = s2_c_q;
   assign out_illegal = s2_illegal_q;

endmodule
